// File: rtl/spart_fifo_bridge.sv
// spart_fifo_bridge: byte FIFOs between the MMU SPART registers and the SPART serial core.
// TX FIFO drains through a 2-state valid/ready output stage; RX FIFO is first-word fall-through.
// Optional build macro SPART_LOOPBACK_EN routes TX accepts into the RX FIFO internally.
module spart_fifo_bridge #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_wr,
  input  logic [7:0] tx_wdata,
  input  logic       rx_rd,
  output logic       spart_tx_full,
  output logic       spart_rx_empty,
  output logic [7:0] spart_rx_data,
  output logic [7:0] ser_tx_data,
  output logic       ser_tx_valid,
  input  logic       ser_tx_ready,
  input  logic [7:0] ser_rx_data,
  input  logic       ser_rx_valid,
  output logic       tx_overflow,
  output logic       rx_overrun,
  input  logic       err_clr
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_HOLD = 1'b1
  } tx_state_e;

  // ---------------------------------------------------------------------------
  // TX FIFO state
  // ---------------------------------------------------------------------------
  logic [7:0]        tx_mem_q [DEPTH];
  logic [ADDR_W-1:0] tx_wptr_q, tx_wptr_d;
  logic [ADDR_W-1:0] tx_rptr_q, tx_rptr_d;
  logic [ADDR_W:0]   tx_cnt_q, tx_cnt_d;
  logic              tx_full_q, tx_full_d;
  logic              tx_empty_q, tx_empty_d;
  logic              tx_overflow_q, tx_overflow_d;
  logic              tx_push;
  logic              tx_pop;
  logic              tx_accept;
  logic              tx_ready_int;

  // Output stage
  tx_state_e         tx_state_q;
  logic              ser_tx_vld_q;
  logic [7:0]        ser_tx_dat_q;

  // ---------------------------------------------------------------------------
  // RX FIFO state
  // ---------------------------------------------------------------------------
  logic [7:0]        rx_mem_q [DEPTH];
  logic [ADDR_W-1:0] rx_wptr_q, rx_wptr_d;
  logic [ADDR_W-1:0] rx_rptr_q, rx_rptr_d;
  logic [ADDR_W:0]   rx_cnt_q, rx_cnt_d;
  logic              rx_full_q, rx_full_d;
  logic              rx_empty_q, rx_empty_d;
  logic [7:0]        rx_head_q, rx_head_d;
  logic              rx_overrun_q, rx_overrun_d;
  logic              rx_push;
  logic              rx_pop;
  logic              rx_in_vld;
  logic [7:0]        rx_in_dat;

  // ---------------------------------------------------------------------------
  // Source selection: external serial core or internal loopback
  // ---------------------------------------------------------------------------
`ifdef SPART_LOOPBACK_EN
  // The RX FIFO is the only consumer, so it alone throttles the output stage.
  assign tx_ready_int = !rx_full_q;
  assign rx_in_vld    = tx_accept;
  assign rx_in_dat    = ser_tx_dat_q;
  assign ser_tx_valid = 1'b0;

  logic unused_loopback;
  assign unused_loopback = ^{ser_tx_ready, ser_rx_valid, ser_rx_data};
`else
  assign tx_ready_int = ser_tx_ready;
  assign rx_in_vld    = ser_rx_valid;
  assign rx_in_dat    = ser_rx_data;
  assign ser_tx_valid = ser_tx_vld_q;
`endif

  assign ser_tx_data    = ser_tx_dat_q;
  assign spart_tx_full  = tx_full_q;
  assign spart_rx_empty = rx_empty_q;
  assign spart_rx_data  = rx_head_q;
  assign tx_overflow    = tx_overflow_q;
  assign rx_overrun     = rx_overrun_q;

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------

  // TX next-state: full/empty are judged on the pre-cycle count, so a write
  // into a full FIFO is rejected even if the output stage dequeues this cycle.
  always_comb begin
    tx_push       = tx_wr && !tx_full_q;
    tx_accept     = (tx_state_q == TX_HOLD) && tx_ready_int;
    tx_pop        = ((tx_state_q == TX_IDLE) || tx_ready_int) && !tx_empty_q;
    tx_wptr_d     = tx_push ? tx_wptr_q + ADDR_W'(1) : tx_wptr_q;
    tx_rptr_d     = tx_pop  ? tx_rptr_q + ADDR_W'(1) : tx_rptr_q;
    tx_cnt_d      = tx_cnt_q + (ADDR_W+1)'(tx_push) - (ADDR_W+1)'(tx_pop);
    tx_full_d     = (tx_cnt_d == FULL_CNT);
    tx_empty_d    = (tx_cnt_d == '0);
    tx_overflow_d = tx_overflow_q;
    if (tx_wr && tx_full_q) begin
      tx_overflow_d = 1'b1;
    end else if (err_clr) begin
      tx_overflow_d = 1'b0;
    end
  end

  // TX pointer, count, flag and sticky-error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wptr_q     <= '0;
      tx_rptr_q     <= '0;
      tx_cnt_q      <= '0;
      tx_full_q     <= 1'b0;
      tx_empty_q    <= 1'b1;
      tx_overflow_q <= 1'b0;
    end else begin
      tx_wptr_q     <= tx_wptr_d;
      tx_rptr_q     <= tx_rptr_d;
      tx_cnt_q      <= tx_cnt_d;
      tx_full_q     <= tx_full_d;
      tx_empty_q    <= tx_empty_d;
      tx_overflow_q <= tx_overflow_d;
    end
  end

  // TX storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (tx_push) begin
      tx_mem_q[tx_wptr_q] <= tx_wdata;
    end
  end

  // TX output stage: loads the head into a held valid/data register and
  // reloads on the accept cycle so back-to-back bytes have no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q   <= TX_IDLE;
      ser_tx_vld_q <= 1'b0;
      ser_tx_dat_q <= 8'h00;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          if (!tx_empty_q) begin
            ser_tx_dat_q <= tx_mem_q[tx_rptr_q];
            ser_tx_vld_q <= 1'b1;
            tx_state_q   <= TX_HOLD;
          end
        end
        TX_HOLD: begin
          if (tx_ready_int) begin
            if (!tx_empty_q) begin
              ser_tx_dat_q <= tx_mem_q[tx_rptr_q];
            end else begin
              ser_tx_vld_q <= 1'b0;
              tx_state_q   <= TX_IDLE;
            end
          end
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // RX FIFO
  // ---------------------------------------------------------------------------

  // RX next-state. The head register tracks mem[rptr]; when the incoming byte
  // lands exactly at the new read pointer (FIFO effectively empty) it must
  // bypass the memory, which is only written at the clock edge.
  always_comb begin
    rx_push      = rx_in_vld && !rx_full_q;
    rx_pop       = rx_rd && !rx_empty_q;
    rx_wptr_d    = rx_push ? rx_wptr_q + ADDR_W'(1) : rx_wptr_q;
    rx_rptr_d    = rx_pop  ? rx_rptr_q + ADDR_W'(1) : rx_rptr_q;
    rx_cnt_d     = rx_cnt_q + (ADDR_W+1)'(rx_push) - (ADDR_W+1)'(rx_pop);
    rx_full_d    = (rx_cnt_d == FULL_CNT);
    rx_empty_d   = (rx_cnt_d == '0);
    rx_head_d    = rx_mem_q[rx_rptr_d];
    if (rx_push && (rx_wptr_q == rx_rptr_d)) begin
      rx_head_d = rx_in_dat;
    end
    rx_overrun_d = rx_overrun_q;
    if (rx_in_vld && rx_full_q) begin
      rx_overrun_d = 1'b1;
    end else if (err_clr) begin
      rx_overrun_d = 1'b0;
    end
  end

  // RX pointer, count, flag, head and sticky-error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wptr_q    <= '0;
      rx_rptr_q    <= '0;
      rx_cnt_q     <= '0;
      rx_full_q    <= 1'b0;
      rx_empty_q   <= 1'b1;
      rx_head_q    <= 8'h00;
      rx_overrun_q <= 1'b0;
    end else begin
      rx_wptr_q    <= rx_wptr_d;
      rx_rptr_q    <= rx_rptr_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_full_q    <= rx_full_d;
      rx_empty_q   <= rx_empty_d;
      rx_head_q    <= rx_head_d;
      rx_overrun_q <= rx_overrun_d;
    end
  end

  // RX storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (rx_push) begin
      rx_mem_q[rx_wptr_q] <= rx_in_dat;
    end
  end

endmodule
